adder_rr_scheduler: RTL and testbench
=====================================

ADDER_RR_SCHEDULER -- requirements
Module: adder_rr_scheduler

Interface
REQ-001 The block SHALL have parameter size, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter NREQ, fixed at 4, giving the number of requesters.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 The block SHALL have port req_valid, input, 4 bits: per-requester operation request.
REQ-006 The block SHALL have port req_a, input, 4*size bits: operand A, requester i in bits [i*size +: size].
REQ-007 The block SHALL have port req_b, input, 4*size bits: operand B, packed as req_a.
REQ-008 The block SHALL have port req_cin, input, 4 bits: per-requester carry-in.
REQ-009 The block SHALL have port req_ready, output, 4 bits: one-hot grant; request i is accepted on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-010 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port res_sum, output, size bits: registered sum.
REQ-013 The block SHALL have port res_cout, output, 1 bit: registered carry-out.
REQ-014 The block SHALL have port res_id, output, 2 bits: index of the requester that owns the result.
REQ-015 The block SHALL have port op_count, output, 16 bits: count of results consumed.

Function
REQ-016 The block SHALL implement FSM states IDLE, COMPUTE and RESULT.
REQ-017 In IDLE, req_ready SHALL be one-hot for the first i with req_valid[i]=1, searching from rr_ptr upward modulo 4; it SHALL be all-zero in other states or when req_valid=0.
REQ-018 On accept, the block SHALL latch a, b, cin and id of the granted requester and move to COMPUTE.
REQ-019 In IDLE with req_valid=0, the block SHALL stay in IDLE.
REQ-020 In COMPUTE, the block SHALL load {res_cout,res_sum} <= a + b + cin, computed at size+1 bits with res_cout as the MSB, set res_valid=1 and res_id=id, and move to RESULT.
REQ-021 In RESULT, the block SHALL hold all res_* outputs stable while res_ready=0.
REQ-022 In RESULT with res_ready=1, the block SHALL clear res_valid, set rr_ptr=(id+1) mod 4, increment op_count (0xFFFF wraps to 0x0000), and return to IDLE.
REQ-023 Accept-to-res_valid latency SHALL be 2 edges; minimum issue interval SHALL be 3 cycles.
REQ-024 Operand changes after accept SHALL NOT affect the in-flight result.
REQ-025 A requester dropping req_valid while not granted SHALL NOT be served; a later grant SHALL use the current valids.
REQ-026 res_sum and res_cout SHALL keep their last value after consumption until the next COMPUTE.

Reset
REQ-027 On a rising edge with rst=0, the block SHALL set state=IDLE, rr_ptr=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, op_count=0 and clear the latched operands, overriding any other event on that edge.
REQ-028 A reset in COMPUTE or RESULT SHALL discard the in-flight operation with no result emitted.
REQ-029 While rst=0, req_ready SHALL be 0.

Verification (size=16)
REQ-030 The bench SHALL drive a single request: req_valid=0001, a=0x0003, b=0x0004, cin=1, res_ready=1 -> res_valid 2 edges after accept, res_sum=0x0008, res_cout=0, res_id=0, op_count=1.
REQ-031 The bench SHALL test overflow: a=0xFFFF, b=0x0001, cin=0 -> res_sum=0x0000, res_cout=1; a=0xFFFF, b=0xFFFF, cin=1 -> res_sum=0xFFFF, res_cout=1.
REQ-032 The bench SHALL test round-robin: req_valid=1111 held -> grant order 0,1,2,3,0 with res_id matching each.
REQ-033 The bench SHALL test backpressure: res_ready=0 for 5 cycles in RESULT -> outputs stable, req_ready=0000; res_ready=1 -> one consumption, op_count +1.
REQ-034 The bench SHALL test mid-operation reset: rst=0 on the edge entering RESULT -> res_valid=0, op_count=0, rr_ptr=0; next request from requester 2 alone is granted.
REQ-035 The bench SHALL test counter wrap: preload 65535 completions (or force) -> one more consumption gives op_count=0x0000.

Source files
------------

// File: rtl/adder_rr_scheduler.sv
// Shared adder serving four requesters in round-robin order.
// One operation in flight; result held until the consumer takes it.
module adder_rr_scheduler #(
    parameter int size = 16,
    parameter int NREQ = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*size-1:0] req_a,
    input  logic [NREQ*size-1:0] req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [size-1:0]      res_sum,
    output logic                 res_cout,
    output logic [1:0]           res_id,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {IDLE, COMPUTE, RESULT} state_t;

    state_t          state;
    state_t          state_d;
    logic [1:0]      rr_ptr;
    logic [1:0]      gnt_id;
    logic            found;
    logic            accept;
    logic [1:0]      id_q;
    logic [size-1:0] a_q;
    logic [size-1:0] b_q;
    logic            cin_q;
    logic [size:0]   sum_w;

    // Find the first valid requester at or after rr_ptr, wrapping at 4.
    always_comb begin
        found  = 1'b0;
        gnt_id = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[rr_ptr + 2'(k)]) begin
                found  = 1'b1;
                gnt_id = rr_ptr + 2'(k);
            end
        end
    end

    // Grant is offered only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE && found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept = |(req_ready & req_valid);
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q} + {{size{1'b0}}, cin_q};

    // Next-state logic for the issue / compute / hold sequence.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept) state_d = COMPUTE;
            COMPUTE: state_d = RESULT;
            RESULT:  if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Operand capture, result register, pointer and completion counter.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            rr_ptr    <= 2'd0;
            id_q      <= 2'd0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 2'd0;
            op_count  <= 16'd0;
        end else begin
            if (state == IDLE && accept) begin
                id_q  <= gnt_id;
                a_q   <= req_a[gnt_id*size +: size];
                b_q   <= req_b[gnt_id*size +: size];
                cin_q <= req_cin[gnt_id];
            end
            if (state == COMPUTE) begin
                {res_cout, res_sum} <= sum_w;
                res_valid           <= 1'b1;
                res_id              <= id_q;
            end
            if (state == RESULT && res_ready) begin
                res_valid <= 1'b0;
                rr_ptr    <= id_q + 2'd1;
                op_count  <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler.
// Expected results are queued at issue and popped when the result shows up.
module tb_adder_rr_scheduler;

    localparam int W = 16;

    logic          clk_in = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [3:0]    req_cin;
    logic [3:0]    req_ready;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    logic [1:0]    res_id;
    logic [15:0]   op_count;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic [1:0]   id;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rr_m = 0;
    int          pend_id = 0;
    logic [15:0] cnt_m = 16'd0;

    adder_rr_scheduler #(.size(W), .NREQ(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr_m + k) % 4]) return (rr_m + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] x);
        return {4{x}};
    endfunction

    task automatic apply_reset();
        @(negedge clk_in);
        rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
        rr_m = 0;
        cnt_m = 16'd0;
        sb.delete();
    endtask

    // Drive one request, queue its expected result, wait for res_valid.
    task automatic send(input logic [3:0] v, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] cin,
                        input bit scramble,
                        output logic [3:0] gnt, output int lat);
        exp_t e;
        int   g;
        @(negedge clk_in);
        req_valid = v;
        req_a = a;
        req_b = b;
        req_cin = cin;
        #1;
        gnt = req_ready;
        g = model_grant(v);
        if (g >= 0) begin
            e.id = 2'(g);
            {e.cout, e.sum} = {1'b0, a[g*W +: W]} + {1'b0, b[g*W +: W]}
                              + 17'(cin[g]);
            sb.push_back(e);
            pend_id = g;
        end
        @(posedge clk_in);
        acc_cyc = cyc;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (scramble && i == 0) begin
                req_a = ~req_a;
                req_b = ~req_b;
                req_cin = ~req_cin;
            end
            if (res_valid) break;
            @(posedge clk_in);
            lat++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk_in);
        #1;
        req_valid = '0;
        rr_m = (pend_id + 1) % 4;
        cnt_m = cnt_m + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        res_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        @(negedge clk_in);
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0000)
            $display("FAIL rst_ready: got %b want 0000", req_ready);
        else passed++;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL rst_valid: got %b want 0", res_valid);
        else passed++;
        total++;
        if ({res_cout, res_sum} !== 17'd0)
            $display("FAIL rst_sum: got %h want 0", {res_cout, res_sum});
        else passed++;
        total++;
        if (res_id !== 2'd0 || op_count !== 16'd0)
            $display("FAIL rst_id_cnt: got %0d/%0d want 0/0", res_id, op_count);
        else passed++;
        req_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] gnt;
        int         lat;
        exp_t       e;
        res_ready = 1'b1;
        send(4'b0001, rep(16'h0003), rep(16'h0004), 4'b0001, 0, gnt, lat);
        total++;
        if (gnt !== 4'b0001)
            $display("FAIL single_gnt: got %b want 0001", gnt);
        else passed++;
        total++;
        if (lat !== 2)
            $display("FAIL single_latency: got %0d want 2", lat);
        else passed++;
        e = sb.pop_front();
        total++;
        if (res_sum !== e.sum || res_sum !== 16'h0008)
            $display("FAIL single_sum: got %h want %h", res_sum, e.sum);
        else passed++;
        total++;
        if (res_cout !== 1'b0 || res_id !== e.id)
            $display("FAIL single_cout_id: got %b/%0d want 0/%0d",
                     res_cout, res_id, e.id);
        else passed++;
        consume();
        total++;
        if (op_count !== cnt_m)
            $display("FAIL single_count: got %0d want %0d", op_count, cnt_m);
        else passed++;
        total++;
        if (res_valid !== 1'b0 || res_sum !== 16'h0008)
            $display("FAIL single_hold_after: got %b/%h want 0/0008",
                     res_valid, res_sum);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [15:0] ta[2] = '{16'hFFFF, 16'hFFFF};
        logic [15:0] tb[2] = '{16'h0001, 16'hFFFF};
        logic [3:0]  tc[2] = '{4'b0000, 4'b0001};
        logic [16:0] tw[2] = '{17'h10000, 17'h1FFFF};
        logic [3:0]  gnt;
        int          lat;
        exp_t        e;
        res_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(4'b0001, rep(ta[i]), rep(tb[i]), tc[i], 0, gnt, lat);
            e = sb.pop_front();
            total++;
            if ({res_cout, res_sum} !== {e.cout, e.sum}
                || {res_cout, res_sum} !== tw[i])
                $display("FAIL overflow_%0d: got %h want %h", i,
                         {res_cout, res_sum}, tw[i]);
            else passed++;
            consume();
        end
    endtask

    task automatic test_operand_hold();
        logic [3:0] gnt;
        int         lat;
        exp_t       e;
        res_ready = 1'b1;
        send(4'b0010, rep(16'h1234), rep(16'h1111), 4'b0000, 1, gnt, lat);
        e = sb.pop_front();
        total++;
        if (res_sum !== e.sum || res_cout !== e.cout || res_id !== 2'd1)
            $display("FAIL operand_hold: got %h/%b/%0d want %h/%b/1",
                     res_sum, res_cout, res_id, e.sum, e.cout);
        else passed++;
        consume();
    endtask

    task automatic test_round_robin();
        int         order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] gnt;
        logic [63:0] a;
        int         lat;
        int         prev;
        exp_t       e;
        apply_reset();
        res_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            a = {16'h4000, 16'h3000, 16'h2000, 16'h1000} + rep(16'(i));
            send(4'b1111, a, rep(16'h0101 * 16'(i + 1)), 4'b1010, 0, gnt, lat);
            e = sb.pop_front();
            total++;
            if (gnt !== 4'(1 << order[i]))
                $display("FAIL rr_gnt_%0d: got %b want slot %0d", i, gnt, order[i]);
            else passed++;
            total++;
            if (res_id !== 2'(order[i]) || res_sum !== e.sum
                || res_cout !== e.cout)
                $display("FAIL rr_res_%0d: got %0d/%h want %0d/%h", i,
                         res_id, res_sum, order[i], e.sum);
            else passed++;
            if (i > 0) begin
                total++;
                if (acc_cyc - prev !== 3)
                    $display("FAIL rr_interval_%0d: got %0d want 3", i,
                             acc_cyc - prev);
                else passed++;
            end
            prev = acc_cyc;
            consume();
        end
        total++;
        if (op_count !== cnt_m)
            $display("FAIL rr_count: got %0d want %0d", op_count, cnt_m);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [3:0] gnt;
        int         lat;
        exp_t       e;
        res_ready = 1'b0;
        send(4'b1111, rep(16'hA5A5), rep(16'h5A5A), 4'b1111, 0, gnt, lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            total++;
            if (res_valid !== 1'b1 || res_sum !== e.sum || res_cout !== e.cout
                || res_id !== e.id || req_ready !== 4'b0000)
                $display("FAIL bp_hold_%0d: got %b/%h/%b/%0d/%b want 1/%h/%b/%0d/0000",
                         i, res_valid, res_sum, res_cout, res_id, req_ready,
                         e.sum, e.cout, e.id);
            else passed++;
        end
        consume();
        total++;
        if (op_count !== cnt_m || res_valid !== 1'b0)
            $display("FAIL bp_consume: got %0d/%b want %0d/0",
                     op_count, res_valid, cnt_m);
        else passed++;
        @(negedge clk_in);
        total++;
        if (op_count !== cnt_m)
            $display("FAIL bp_single: got %0d want %0d", op_count, cnt_m);
        else passed++;
    endtask

    task automatic test_mid_reset();
        logic [3:0] gnt;
        int         lat;
        exp_t       e;
        res_ready = 1'b0;
        @(negedge clk_in);
        req_valid = 4'b0001;
        req_a = rep(16'h0100);
        req_b = rep(16'h0200);
        req_cin = '0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk_in);
        @(negedge clk_in);
        total++;
        if (res_valid !== 1'b0 || op_count !== 16'd0 || res_sum !== 16'd0)
            $display("FAIL midrst_clear: got %b/%0d/%h want 0/0/0",
                     res_valid, op_count, res_sum);
        else passed++;
        rst = 1'b1;
        rr_m = 0;
        cnt_m = 16'd0;
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL midrst_ptr: got %b want 0001", req_ready);
        else passed++;
        req_valid = '0;
        @(posedge clk_in);
        #1;
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL midrst_no_result: got %b want 0", res_valid);
        else passed++;
        res_ready = 1'b1;
        send(4'b0100, rep(16'h0010), rep(16'h0020), 4'b0100, 0, gnt, lat);
        e = sb.pop_front();
        total++;
        if (gnt !== 4'b0100 || res_id !== 2'd2 || res_sum !== e.sum)
            $display("FAIL midrst_req2: got %b/%0d/%h want 0100/2/%h",
                     gnt, res_id, res_sum, e.sum);
        else passed++;
        consume();
        total++;
        if (op_count !== cnt_m)
            $display("FAIL midrst_count: got %0d want %0d", op_count, cnt_m);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] gnt;
        int         lat;
        exp_t       e;
        @(negedge clk_in);
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        cnt_m = 16'hFFFF;
        total++;
        if (op_count !== 16'hFFFF)
            $display("FAIL wrap_preload: got %h want ffff", op_count);
        else passed++;
        res_ready = 1'b1;
        send(4'b1000, rep(16'h0007), rep(16'h0008), 4'b0000, 0, gnt, lat);
        e = sb.pop_front();
        total++;
        if (res_sum !== e.sum || res_id !== e.id)
            $display("FAIL wrap_result: got %h/%0d want %h/%0d",
                     res_sum, res_id, e.sum, e.id);
        else passed++;
        consume();
        total++;
        if (op_count !== cnt_m || op_count !== 16'h0000)
            $display("FAIL wrap_count: got %h want 0000", op_count);
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_operand_hold();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
